serial_ovf_adder: RTL and testbench
===================================

# serial_ovf_adder

Multi-cycle, parametrised two's-complement adder/subtractor with signed-overflow detection and optional saturation. Processes operands CHUNK bits per clock, LSB chunk first, under a start/busy/done handshake. It succeeds the fixed 8-bit combinational sum/overflow adder. Intended for datapaths where a full-width ripple adder misses timing or area budget.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥2 and a multiple of CHUNK
- CHUNK, 2, bits processed per cycle; N = WIDTH/CHUNK RUN cycles per operation
- clk  input  1  rising-edge clock, sole clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  signed operand A, sampled with accepted start
- b  input  WIDTH  signed operand B, sampled with accepted start
- sub  input  1  0: a+b, 1: a−b; sampled with accepted start
- sat  input  1  1: saturate on overflow; sampled with accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- s  output  WIDTH  result, held from done until next accepted start
- over  output  1  signed overflow of the unsaturated result, held with s
- carry  output  1  carry out of MSB (for sub: 1 = no borrow), held with s

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; s, over, carry, busy, done all 0; chunk counter 0.
- Accept: start=1 in IDLE or DONE.
  - Latch a into opA.
  - Latch b into opB, inverted if sub=1.
  - Latch the sat flag; set internal carry = sub.
  - Go to RUN with counter = 0.
- RUN: each cycle, add chunk [counter*CHUNK +: CHUNK] of opA and opB with the internal carry.
  - Write the sum chunk into the partial-result register.
  - Update the internal carry; increment the counter.
  - Start is ignored while in RUN.
- Last chunk (counter = N−1):
  - over = (carry into MSB) XOR (carry out of MSB); carry = carry out of MSB.
  - If sat=1 and over=1, then s = 0x80..0 when opA's sign bit = 1, otherwise s = 0x7F..F. Else s = raw sum.
  - Go to DONE.
- DONE: done=1 for exactly this cycle.
  - Next state is RUN on start=1, else IDLE.
  - s, over, carry hold until the next operation's last RUN cycle.
- Width rule: result wraps modulo 2^WIDTH; no sign extension; the carry out of the final chunk is the only extra bit retained.
- rst=1 in any state, including mid-RUN, overrides everything: IDLE, all outputs 0, operation discarded.

## Timing
- Start accepted at edge k → busy=1 from cycle after k for N cycles.
- done=1, with s/over/carry valid, in the cycle after edge k+N; latency N+1 cycles from start sample to done visible.
- Back-to-back operation: start held during the DONE cycle → busy again next cycle; throughput one result per N+1 cycles.
- Operands a/b/sub/sat may change freely after the accepting edge.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Package serial_ovf_adder_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - helper functions sat_max(WIDTH) / sat_min(WIDTH)
- Sub-module chunk_adder: combinational, parameter CHUNK.
  - Inputs x, y, cin; outputs sum, cout, c_msb (carry into top bit).
  - Instantiated once; the top level supplies the counter-selected slices.
- Top level: FSM, counter of width $clog2(N)+1, operand/result registers.

## Test plan
- WIDTH=8, CHUNK=2, sub=0, sat=0:
  - 0xB2+0xEF → s=0xA1, carry=1, over=0.
  - busy high exactly 4 cycles; done is a single pulse 5 cycles after the start edge.
- 0x92+0x87:
  - sat=0 → s=0x19, over=1, carry=1.
  - sat=1 → s=0x80, over=1.
- 0x32+0x6F:
  - sat=0 → s=0xA1, over=1, carry=0.
  - sat=1 → s=0x7F.
- sub=1: 0x03−0xAF → s=0x54, over=0, carry=0. Then back-to-back 0xDA+0xCF (start held in DONE) → s=0xA9, carry=1, over=0, with no IDLE cycle in between.
- Start pulsed mid-RUN → ignored, result unchanged. rst asserted at RUN cycle 2 → next cycle IDLE, s=0, over=0, done never pulses. A fresh start then completes normally.
- WIDTH=16, CHUNK=4: 0x7FFF+0x0001 → s=0x8000, over=1, with done 5 cycles after start. With sat=1 → s=0x7FFF.

Source files
------------

// File: rtl/serial_ovf_adder_pkg.sv
// rtl/serial_ovf_adder_pkg.sv - shared types and helpers for the serial overflow adder
//
// Contents:
//   state_e   : controller states (IDLE, RUN, DONE)
//   sat_max() : most positive two's-complement value of a given width
//   sat_min() : most negative two's-complement value of a given width
//               (bit pattern 100..0)
// Both helpers return a 64-bit value; callers truncate to their width.

package serial_ovf_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest operand the saturation helpers can describe.
  localparam int unsigned SAT_FN_W = 64;

  // 0111..1 in the low 'width' bits.
  function automatic logic [SAT_FN_W-1:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // 1000..0 in the low 'width' bits.
  function automatic logic [SAT_FN_W-1:0] sat_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/serial_ovf_adder_chunk_adder.sv
// rtl/serial_ovf_adder_chunk_adder.sv - combinational CHUNK-bit adder slice
//
// Ports:
//   x, y   [CHUNK-1:0] in  : operand slices
//   cin                in  : carry into bit 0
//   sum    [CHUNK-1:0] out : x + y + cin, modulo 2^CHUNK
//   cout               out : carry out of bit CHUNK-1
//   c_msb              out : carry into bit CHUNK-1 (used for signed overflow)

module chunk_adder
  import serial_ovf_adder_pkg::*;
#(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] full;

  assign full  = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  assign sum   = full[CHUNK-1:0];
  assign cout  = full[CHUNK];
  // The top sum bit is x ^ y ^ carry_in, so the carry into it falls out
  // without a second, narrower adder.
  assign c_msb = full[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];

endmodule

// File: rtl/serial_ovf_adder.sv
// rtl/serial_ovf_adder.sv - multi-cycle two's-complement add/sub with overflow and saturation
//
// Parameters:
//   WIDTH : operand/result width (>= 2, multiple of CHUNK, <= 64)
//   CHUNK : bits summed per clock; one operation takes N = WIDTH/CHUNK RUN cycles
// Ports:
//   clk                in  : rising-edge clock
//   rst                in  : synchronous active-high reset, overrides everything
//   start              in  : request, honoured only in IDLE or DONE
//   a, b   [WIDTH-1:0] in  : signed operands, captured with an accepted start
//   sub                in  : 0 = a + b, 1 = a - b
//   sat                in  : clamp the result when it overflows
//   busy               out : high during the N RUN cycles
//   done               out : one-cycle pulse, s/over/carry valid
//   s      [WIDTH-1:0] out : result, held until the next operation completes
//   over               out : signed overflow of the unsaturated sum
//   carry              out : carry out of the MSB (subtract: 1 = no borrow)

module serial_ovf_adder
  import serial_ovf_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             over,
  output logic             carry
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N) + 1;

  localparam logic [CW-1:0]    LAST   = CW'(N - 1);
  localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(sat_min(WIDTH));

  // Controller and operand state
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;   // b, already inverted for subtraction
  logic             sat_q;
  logic             cin_q;   // ripple carry between chunks
  logic [WIDTH-1:0] part_q;  // partial sum, filled LSB chunk first

  // Registered outputs
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             over_q;
  logic             carry_q;

  // Chunk datapath
  logic [31:0]      base;
  logic [CHUNK-1:0] ca_x;
  logic [CHUNK-1:0] ca_y;
  logic [CHUNK-1:0] ca_sum;
  logic             ca_cout;
  logic             ca_cmsb;

  // Next-value terms for the final RUN cycle
  logic [WIDTH-1:0] part_d;
  logic [WIDTH-1:0] s_d;
  logic             over_d;

  assign base = 32'(cnt_q) * 32'(CHUNK);
  assign ca_x = opa_q[base +: CHUNK];
  assign ca_y = opb_q[base +: CHUNK];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .x     (ca_x),
    .y     (ca_y),
    .cin   (cin_q),
    .sum   (ca_sum),
    .cout  (ca_cout),
    .c_msb (ca_cmsb)
  );

  // Partial result with the current chunk merged in. On the last chunk this
  // is the complete raw sum, so the final result needs no extra cycle.
  always_comb begin
    part_d               = part_q;
    part_d[base +: CHUNK] = ca_sum;
  end

  // Only meaningful on the last chunk, where c_msb/cout belong to the word MSB.
  assign over_d = ca_cmsb ^ ca_cout;

  // On overflow the true result has the sign of opA (for add both operands
  // share it; for sub -b shares it), so opA's sign picks the clamp rail.
  always_comb begin
    s_d = part_d;
    if (sat_q && over_d) begin
      s_d = opa_q[WIDTH-1] ? SAT_LO : SAT_HI;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sat_q   <= 1'b0;
      cin_q   <= 1'b0;
      part_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      over_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            opa_q   <= a;
            // a - b = a + ~b + 1: invert b here, seed the carry with sub.
            opb_q   <= sub ? ~b : b;
            sat_q   <= sat;
            cin_q   <= sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          part_q <= part_d;
          cin_q  <= ca_cout;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            s_q     <= s_d;
            over_q  <= over_d;
            carry_q <= ca_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign s     = s_q;
  assign over  = over_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_serial_ovf_adder.sv
// tb/tb_serial_ovf_adder.sv - self-checking bench for serial_ovf_adder (8/2 and 16/4 instances)

module tb_serial_ovf_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start8, sub8, sat8, busy8, done8, over8, carry8;
  logic [7:0] a8, b8, s8;

  logic        start16, sub16, sat16, busy16, done16, over16, carry16;
  logic [15:0] a16, b16, s16;

  serial_ovf_adder #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .sub(sub8), .sat(sat8),
    .busy(busy8), .done(done8), .s(s8), .over(over8), .carry(carry8)
  );

  serial_ovf_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .sub(sub16), .sat(sat16),
    .busy(busy16), .done(done16), .s(s16), .over(over16), .carry(carry16)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: exact signed arithmetic, then wrap / clamp.
  function automatic void model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                input logic subv, input logic satv,
                                output logic [15:0] es, output logic eo, output logic ec);
    longint m, hi, lo, ua, ub, sa, sb, tr, u;
    m  = (longint'(1) << w) - 1;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    ua = longint'(av) & m;
    ub = longint'(bv) & m;
    sa = (ua > hi) ? ua - (m + 1) : ua;
    sb = (ub > hi) ? ub - (m + 1) : ub;
    tr = subv ? sa - sb : sa + sb;
    eo = (tr > hi) || (tr < lo);
    u  = subv ? ua + ((~ub) & m) + 1 : ua + ub;
    ec = ((u >> w) & 1) != 0;
    if (eo && satv) es = (tr > 0) ? 16'(hi) : 16'(lo & m);
    else            es = 16'(tr & m);
  endfunction

  function automatic logic [15:0] get_s(input int w);
    return (w == 8) ? {8'h00, s8} : s16;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : done16;
  endfunction
  function automatic logic get_over(input int w);
    return (w == 8) ? over8 : over16;
  endfunction
  function automatic logic get_carry(input int w);
    return (w == 8) ? carry8 : carry16;
  endfunction

  task automatic drive(input int w, input logic st, input logic [15:0] av, input logic [15:0] bv,
                       input logic subv, input logic satv);
    if (w == 8) begin
      start8 = st; a8 = av[7:0]; b8 = bv[7:0]; sub8 = subv; sat8 = satv;
    end else begin
      start16 = st; a16 = av; b16 = bv; sub16 = subv; sat16 = satv;
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or on timeout).
  // poke > 0 pulses start with junk operands during that RUN cycle.
  task automatic run_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                        input logic subv, input logic satv, input int poke);
    logic [15:0] es;
    logic        eo, ec;
    int          n, lat, nbusy;
    n = 4;
    model(w, av, bv, subv, satv, es, eo, ec);
    drive(w, 1'b1, av, bv, subv, satv);
    @(posedge clk);
    lat = 0;
    nbusy = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      // Operands are scrambled after acceptance; the DUT must not care.
      drive(w, (lat == poke), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      if (lat == 1) chk("busy_first", get_busy(w), 1);
      if (get_busy(w)) nbusy++;
      if (get_done(w)) break;
    end
    drive(w, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("latency", lat, n + 1);
    chk("busy_cycles", nbusy, n);
    chk("busy_at_done", get_busy(w), 0);
    chk("s", get_s(w), es);
    chk("over", get_over(w), eo);
    chk("carry", get_carry(w), ec);
  endtask

  task automatic expect_done_drop(input int w);
    @(negedge clk);
    chk("done_pulse", get_done(w), 0);
  endtask

  initial begin
    int          w;
    logic        seen;
    logic [15:0] av, bv;
    rst = 1'b1;
    drive(8, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(16, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_s8", s8, 0);
    chk("rst_over8", over8, 0);
    chk("rst_carry8", carry8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_s16", s16, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8, 16'hB2, 16'hEF, 0, 0, 0);
    chk("B2+EF_s", s8, 8'hA1);
    chk("B2+EF_carry", carry8, 1);
    expect_done_drop(8);

    run_op(8, 16'h92, 16'h87, 0, 0, 0);
    chk("92+87_s", s8, 8'h19);
    chk("92+87_over", over8, 1);
    expect_done_drop(8);
    run_op(8, 16'h92, 16'h87, 0, 1, 0);
    chk("92+87_sat", s8, 8'h80);
    expect_done_drop(8);

    run_op(8, 16'h32, 16'h6F, 0, 0, 0);
    chk("32+6F_s", s8, 8'hA1);
    chk("32+6F_carry", carry8, 0);
    expect_done_drop(8);
    run_op(8, 16'h32, 16'h6F, 0, 1, 0);
    chk("32+6F_sat", s8, 8'h7F);
    expect_done_drop(8);

    // Subtract, then back-to-back add with start held in DONE.
    run_op(8, 16'h03, 16'hAF, 1, 0, 0);
    chk("03-AF_s", s8, 8'h54);
    run_op(8, 16'hDA, 16'hCF, 0, 0, 0);
    chk("DA+CF_s", s8, 8'hA9);
    expect_done_drop(8);

    // Start pulsed mid-RUN is ignored.
    run_op(8, 16'h5C, 16'h71, 1, 1, 2);
    expect_done_drop(8);
    @(negedge clk);
    chk("ignored_start_idle", busy8, 0);

    // Load a nonzero result, then reset during RUN cycle 2.
    run_op(8, 16'hDA, 16'hCF, 0, 0, 0);
    expect_done_drop(8);
    drive(8, 1'b1, 16'h12, 16'h34, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(8, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy8, 0);
    chk("midrst_s", s8, 0);
    chk("midrst_over", over8, 0);
    chk("midrst_carry", carry8, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 0);
    run_op(8, 16'h40, 16'h40, 0, 0, 0);
    expect_done_drop(8);

    // 16-bit, 4-bit chunks.
    run_op(16, 16'h7FFF, 16'h0001, 0, 0, 0);
    chk("7FFF+1_s", s16, 16'h8000);
    chk("7FFF+1_over", over16, 1);
    expect_done_drop(16);
    run_op(16, 16'h7FFF, 16'h0001, 0, 1, 0);
    chk("7FFF+1_sat", s16, 16'h7FFF);
    expect_done_drop(16);

    // Edge operands and random traffic, sometimes back-to-back.
    run_op(8, 16'h80, 16'h80, 1, 1, 0);
    expect_done_drop(8);
    run_op(16, 16'h8000, 16'h0001, 1, 1, 0);
    expect_done_drop(16);
    for (int i = 0; i < 60; i++) begin
      w  = ($urandom_range(1) == 0) ? 8 : 16;
      av = 16'($urandom);
      bv = 16'($urandom);
      run_op(w, av, bv, 1'($urandom), 1'($urandom), ($urandom_range(3) == 0) ? 3 : 0);
      if ($urandom_range(2) != 0) expect_done_drop(w);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
